// File: rtl/fp_addsub_exec_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : fp_addsub_exec_pipe
//  Function : FP add/sub mantissa execution stage. Resolves effective op and
//             result sign, adds/subtracts aligned mantissas and carries the
//             result through STAGES valid/ready pipeline registers.
//  Option   : FPADDSUB_EXEC_ZERO_DET_EN adds the Zero output and forces +0
//             on exact cancellation.
//  Revision : 1.0  initial release
// ============================================================================
module fp_addsub_exec_pipe #(
   parameter int MAN_W  = 25,
   parameter int STAGES = 2
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             InValid,
   output logic             InReady,
   input  logic [MAN_W-1:0] Mmax,
   input  logic [MAN_W-1:0] Mmin,
   input  logic             Sa,
   input  logic             Sb,
   input  logic             MaxAB,
   input  logic             OpMode,
   input  logic             G,
   input  logic             PS,
   output logic             OutValid,
   input  logic             OutReady,
   output logic [MAN_W:0]   Sum,
   output logic             PSgn,
   output logic             Opr
`ifdef FPADDSUB_EXEC_ZERO_DET_EN
   ,
   output logic             Zero
`endif
);

   localparam int SUM_W = MAN_W + 1;
`ifdef FPADDSUB_EXEC_ZERO_DET_EN
   localparam int PL_W  = SUM_W + 3;
`else
   localparam int PL_W  = SUM_W + 2;
`endif

   generate
      if (STAGES < 1 || STAGES > 4) begin : g_bad_stages
         $error("fp_addsub_exec_pipe: STAGES must be in 1..4");
      end
   endgenerate

   logic             w_opr;
   logic [SUM_W-1:0] w_addend;
   logic [SUM_W-1:0] w_cin;
   logic [SUM_W-1:0] w_sum;
   logic             w_psgn_raw;
   logic [PL_W-1:0]  w_payload;
   logic             w_adv;
`ifdef FPADDSUB_EXEC_ZERO_DET_EN
   logic             w_zero;
   logic             w_psgn;
`endif

   // The +1 completes the two's complement only when no guard/sticky bits
   // were shifted out; otherwise the borrow is absorbed by those bits.
   always_comb begin
      w_opr      = OpMode ^ Sa ^ Sb;
      w_addend   = w_opr ? ~{1'b0, Mmin} : {1'b0, Mmin};
      w_cin      = {{MAN_W{1'b0}}, w_opr & ~(G | PS)};
      w_sum      = {1'b0, Mmax} + w_addend + w_cin;
      w_psgn_raw = MaxAB ? Sb : Sa;
`ifdef FPADDSUB_EXEC_ZERO_DET_EN
      w_zero     = (w_sum == '0);
      w_psgn     = w_psgn_raw & ~(w_zero & w_opr);
      w_payload  = {w_sum, w_psgn, w_opr, w_zero};
`else
      w_payload  = {w_sum, w_psgn_raw, w_opr};
`endif
   end

   logic            r_vld [STAGES];
   logic [PL_W-1:0] r_pl  [STAGES];

   assign w_adv    = ~r_vld[STAGES-1] | OutReady;
   assign InReady  = w_adv;
   assign OutValid = r_vld[STAGES-1];

`ifdef FPADDSUB_EXEC_ZERO_DET_EN
   assign {Sum, PSgn, Opr, Zero} = r_pl[STAGES-1];
`else
   assign {Sum, PSgn, Opr} = r_pl[STAGES-1];
`endif

   // Global stall: all stages shift together; payload only loads behind a valid.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         for (int k = 0; k < STAGES; k++) begin
            r_vld[k] <= 1'b0;
            r_pl[k]  <= '0;
         end
      end else if (w_adv) begin
         r_vld[0] <= InValid;
         if (InValid) begin
            r_pl[0] <= w_payload;
         end
         for (int k = 1; k < STAGES; k++) begin
            r_vld[k] <= r_vld[k-1];
            if (r_vld[k-1]) begin
               r_pl[k] <= r_pl[k-1];
            end
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_fp_addsub_exec_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fp_addsub_exec_pipe
//  Function : Scoreboard bench for fp_addsub_exec_pipe at STAGES = 2, 1, 4.
//  Revision : 1.0  initial release
// ============================================================================
module tb_fp_addsub_exec_pipe;

   localparam int NDUT = 3;

   typedef struct {
      logic [24:0] mmax;
      logic [24:0] mmin;
      logic        sa, sb, maxab, op, g, ps;
      logic [25:0] esum;
      logic        epsgn, eopr, ezero;
   } vec_t;

   typedef struct {
      logic [25:0] s;
      logic        p, o, z;
      int          cyc;
      bit          lat;
   } exp_t;

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic        in_valid  [NDUT];
   logic        in_ready  [NDUT];
   logic [24:0] mmax      [NDUT];
   logic [24:0] mmin      [NDUT];
   logic        sa        [NDUT];
   logic        sb        [NDUT];
   logic        maxab     [NDUT];
   logic        opmode    [NDUT];
   logic        g         [NDUT];
   logic        ps        [NDUT];
   logic        out_valid [NDUT];
   logic        out_ready [NDUT];
   logic [25:0] sum       [NDUT];
   logic        psgn      [NDUT];
   logic        opr       [NDUT];
   logic        zero      [NDUT];

   exp_t q [NDUT][$];
   vec_t vt [14];
   int   cyc = 0;
   int   ncmp = 0;
   int   nerr = 0;
   bit   end_chk = 1'b0;

   always #5 CLK = ~CLK;
   always @(posedge CLK) cyc <= cyc + 1;

   genvar gk;
   generate
      for (gk = 0; gk < NDUT; gk++) begin : g_dut
         fp_addsub_exec_pipe #(
            .MAN_W  (25),
            .STAGES (gk == 0 ? 2 : (gk == 1 ? 1 : 4))
         ) u_dut (
            .CLK      (CLK),
            .RST      (RST),
            .InValid  (in_valid[gk]),
            .InReady  (in_ready[gk]),
            .Mmax     (mmax[gk]),
            .Mmin     (mmin[gk]),
            .Sa       (sa[gk]),
            .Sb       (sb[gk]),
            .MaxAB    (maxab[gk]),
            .OpMode   (opmode[gk]),
            .G        (g[gk]),
            .PS       (ps[gk]),
            .OutValid (out_valid[gk]),
            .OutReady (out_ready[gk]),
            .Sum      (sum[gk]),
            .PSgn     (psgn[gk]),
`ifdef FPADDSUB_EXEC_ZERO_DET_EN
            .Opr      (opr[gk]),
            .Zero     (zero[gk])
`else
            .Opr      (opr[gk])
`endif
         );
`ifndef FPADDSUB_EXEC_ZERO_DET_EN
         assign zero[gk] = 1'b0;
`endif
      end
   endgenerate

   function automatic int stg(input int k);
      return (k == 0) ? 2 : ((k == 1) ? 1 : 4);
   endfunction

   // Scoreboard monitor: the only process that counts comparisons.
   logic [28:0] got, ex;
   always @(negedge CLK) begin
      for (int k = 0; k < NDUT; k++) begin
         if (RST) begin
            ncmp++;
            if (out_valid[k] !== 1'b0 || sum[k] !== 26'h0 || psgn[k] !== 1'b0 ||
                opr[k] !== 1'b0 || zero[k] !== 1'b0 || in_ready[k] !== 1'b1) begin
               nerr++;
               $display("FAIL reset_state dut%0d: vld=%b sum=%h psgn=%b opr=%b zero=%b rdy=%b, required 0 0 0 0 0 1",
                        k, out_valid[k], sum[k], psgn[k], opr[k], zero[k], in_ready[k]);
            end
         end else if (out_valid[k]) begin
            got = {sum[k], psgn[k], opr[k], zero[k]};
            if (q[k].size() == 0) begin
               ncmp++; nerr++;
               $display("FAIL unexpected_beat dut%0d: got %h, scoreboard empty", k, got);
            end else if (out_ready[k]) begin
               exp_t e;
               e  = q[k].pop_front();
               ex = {e.s, e.p, e.o, e.z};
               ncmp++;
               if (got !== ex) begin
                  nerr++;
                  $display("FAIL payload dut%0d: got {sum,psgn,opr,zero}=%h, required %h", k, got, ex);
               end
               if (e.lat) begin
                  ncmp++;
                  if (cyc - e.cyc != stg(k)) begin
                     nerr++;
                     $display("FAIL latency dut%0d: got %0d cycles, required %0d", k, cyc - e.cyc, stg(k));
                  end
               end
            end else begin
               ex = {q[k][0].s, q[k][0].p, q[k][0].o, q[k][0].z};
               ncmp++;
               if (got !== ex || in_ready[k] !== 1'b0) begin
                  nerr++;
                  $display("FAIL stall_hold dut%0d: got %h rdy=%b, required %h rdy=0", k, got, in_ready[k], ex);
               end
            end
         end
         if (end_chk) begin
            ncmp++;
            if (q[k].size() != 0) begin
               nerr++;
               $display("FAIL drain dut%0d: %0d beats missing, required 0", k, q[k].size());
            end
         end
      end
   end

   task automatic idle(input int k);
      in_valid[k] = 1'b0;
   endtask

   // Entered and left at posedge+1; beat is pushed when it will transfer.
   task automatic send(input int k, input vec_t v, input bit lat);
      exp_t e;
      in_valid[k] = 1'b1;
      mmax[k] = v.mmax; mmin[k] = v.mmin; sa[k] = v.sa; sb[k] = v.sb;
      maxab[k] = v.maxab; opmode[k] = v.op; g[k] = v.g; ps[k] = v.ps;
      for (int t = 0; t < 40; t++) begin
         #1;
         if (in_ready[k]) begin
            e.s = v.esum; e.p = v.epsgn; e.o = v.eopr;
`ifdef FPADDSUB_EXEC_ZERO_DET_EN
            e.z = v.ezero;
`else
            e.z = 1'b0;
`endif
            e.cyc = cyc; e.lat = lat;
            q[k].push_back(e);
            @(posedge CLK); #1;
            return;
         end
         @(posedge CLK); #1;
      end
      $display("FAIL send_timeout dut%0d: InReady stayed 0 for 40 cycles, required 1", k);
      $fatal(1, "send timeout");
   endtask

   task automatic wait_cycles(input int n);
      repeat (n) @(posedge CLK);
      #1;
   endtask

   task automatic run_basic(input int k);
      out_ready[k] = 1'b1;
      for (int i = 0; i < 8; i++) send(k, vt[i], 1'b1);
      idle(k);
      wait_cycles(stg(k) + 3);
   endtask

   task automatic run_bp(input int k);
      fork
         begin
            for (int i = 8; i < 14; i++) send(k, vt[i], 1'b0);
            idle(k);
         end
         begin
            for (int c = 0; c < 20; c++) begin
               out_ready[k] = !(c >= 3 && c <= 5);
               @(posedge CLK); #1;
            end
         end
      join
      out_ready[k] = 1'b1;
      wait_cycles(stg(k) + 3);
   endtask

   task automatic run_rst(input int k);
      out_ready[k] = 1'b1;
      send(k, vt[0], 1'b0);
      send(k, vt[1], 1'b0);
      idle(k);
      RST = 1'b1;
      for (int j = 0; j < NDUT; j++) q[j].delete();
      wait_cycles(2);
      RST = 1'b0;
      wait_cycles(8);
   endtask

   initial begin
      for (int k = 0; k < NDUT; k++) begin
         in_valid[k] = 1'b0; mmax[k] = '0; mmin[k] = '0; sa[k] = 1'b0; sb[k] = 1'b0;
         maxab[k] = 1'b0; opmode[k] = 1'b0; g[k] = 1'b0; ps[k] = 1'b0; out_ready[k] = 1'b1;
      end
      //           mmax         mmin         sa    sb    maxab op    g     ps    esum          psgn  opr   zero
      vt[0]  = '{25'h1000000, 25'h0800000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 26'h1800000, 1'b0, 1'b0, 1'b0};
      vt[1]  = '{25'h1000000, 25'h0800000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 26'h0800000, 1'b0, 1'b1, 1'b0};
      vt[2]  = '{25'h1000000, 25'h0800000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 26'h07FFFFF, 1'b0, 1'b1, 1'b0};
      vt[3]  = '{25'h1000000, 25'h0800000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 26'h0800000, 1'b1, 1'b1, 1'b0};
      vt[4]  = '{25'h1234567, 25'h1234567, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 26'h0000000, 1'b0, 1'b1, 1'b1};
`ifdef FPADDSUB_EXEC_ZERO_DET_EN
      vt[5]  = '{25'h1234567, 25'h1234567, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 26'h0000000, 1'b0, 1'b1, 1'b1};
`else
      vt[5]  = '{25'h1234567, 25'h1234567, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 26'h0000000, 1'b1, 1'b1, 1'b1};
`endif
      vt[6]  = '{25'h1FFFFFF, 25'h1FFFFFF, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 26'h3FFFFFE, 1'b1, 1'b0, 1'b0};
      vt[7]  = '{25'h1000000, 25'h0000001, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 26'h0FFFFFE, 1'b0, 1'b1, 1'b0};
      vt[8]  = '{25'h0000010, 25'h0000000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 26'h0000010, 1'b0, 1'b0, 1'b0};
      vt[9]  = '{25'h0000020, 25'h0000001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 26'h0000021, 1'b0, 1'b0, 1'b0};
      vt[10] = '{25'h0000030, 25'h0000002, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 26'h0000032, 1'b0, 1'b0, 1'b0};
      vt[11] = '{25'h0000040, 25'h0000003, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 26'h0000043, 1'b0, 1'b0, 1'b0};
      vt[12] = '{25'h0000050, 25'h0000004, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 26'h0000054, 1'b0, 1'b0, 1'b0};
      vt[13] = '{25'h0000060, 25'h0000005, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 26'h0000065, 1'b0, 1'b0, 1'b0};

      RST = 1'b1;
      wait_cycles(3);
      RST = 1'b0;
      wait_cycles(2);

      for (int k = 0; k < NDUT; k++) begin
         run_basic(k);
         run_bp(k);
         run_rst(k);
      end

      end_chk = 1'b1;
      @(negedge CLK);
      #1;
      end_chk = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
      $finish;
   end

endmodule
`default_nettype wire
